// File: rtl/parity_frame_gen.sv
// ---------------------------------------------------------------------------
// parity_frame_gen
//
// Streaming parity generator for framed data. This block sits between a
// framed data source and a serial/link transmitter.
//
// Each accepted WIDTH-bit word goes out one cycle later with a parity bit in
// the MSB. The frame's parity mode (even or odd) is taken from odd_mode on the
// frame's first accepted word and then held until the frame ends. After the
// last word of a frame, the block sends one trailer beat. The trailer carries
// the frame's LRC (the XOR of all words) with its own parity bit on top.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   odd_mode     in   0 = even parity, 1 = odd parity (sampled on first beat)
//   s_valid      in   input word valid
//   s_ready      out  block can accept an input word
//   s_data       in   [WIDTH-1:0] input word
//   s_last       in   input word ends the frame
//   m_valid      out  output beat valid
//   m_ready      in   downstream accepts the output beat
//   m_data       out  [WIDTH:0] {parity_bit, word}
//   m_trailer    out  current output beat is the LRC trailer
//   m_last       out  frame end, only on trailer beats
//   frame_count  out  [CNT_W-1:0] trailers accepted downstream, wraps
// ---------------------------------------------------------------------------
module parity_frame_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH:0]   m_data,
  output logic             m_trailer,
  output logic             m_last,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic {
    ST_DATA  = 1'b0,
    ST_TRAIL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lrc_q, lrc_d;
  logic               first_beat_q, first_beat_d;
  logic               mode_q, mode_d;
  logic               m_valid_q, m_valid_d;
  logic [WIDTH:0]     m_data_q, m_data_d;
  logic               m_trailer_q, m_trailer_d;
  logic               m_last_q, m_last_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;

  logic               out_free;
  logic               accept;
  logic               beat_mode;

  // The single output register can take a new beat when it is empty or when
  // its current beat leaves in this same cycle.
  assign out_free  = !m_valid_q || m_ready;
  assign s_ready   = (state_q == ST_DATA) && out_free;
  assign accept    = s_valid && s_ready;

  // On the first word of a frame, mode_q still holds the previous frame's
  // mode. That word therefore uses the live odd_mode input instead.
  assign beat_mode = first_beat_q ? odd_mode : mode_q;

  // Next-state logic for the frame FSM, the LRC accumulator, the output
  // register and the frame counter. Every value defaults to "hold".
  always_comb begin
    state_d       = state_q;
    lrc_d         = lrc_q;
    first_beat_d  = first_beat_q;
    mode_d        = mode_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_trailer_d   = m_trailer_q;
    m_last_d      = m_last_q;
    frame_count_d = frame_count_q;

    // The current beat is consumed. If nothing is loaded below, the output
    // register becomes empty.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      if (m_trailer_q) begin
        frame_count_d = frame_count_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_DATA: begin
        if (accept) begin
          m_valid_d    = 1'b1;
          m_data_d     = {(^s_data) ^ beat_mode, s_data};
          m_trailer_d  = 1'b0;
          m_last_d     = 1'b0;
          lrc_d        = lrc_q ^ s_data;
          first_beat_d = 1'b0;
          if (first_beat_q) begin
            mode_d = odd_mode;
          end
          if (s_last) begin
            state_d = ST_TRAIL;
          end
        end
      end

      ST_TRAIL: begin
        // lrc_q already includes the last word, because that word was
        // folded in when it was accepted.
        if (out_free) begin
          m_valid_d    = 1'b1;
          m_data_d     = {(^lrc_q) ^ mode_q, lrc_q};
          m_trailer_d  = 1'b1;
          m_last_d     = 1'b1;
          lrc_d        = '0;
          first_beat_d = 1'b1;
          state_d      = ST_DATA;
        end
      end

      default: begin
        state_d = ST_DATA;
      end
    endcase
  end

  // State register. Synchronous reset discards any partial frame and
  // empties the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_DATA;
      lrc_q         <= '0;
      first_beat_q  <= 1'b1;
      mode_q        <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_trailer_q   <= 1'b0;
      m_last_q      <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      lrc_q         <= lrc_d;
      first_beat_q  <= first_beat_d;
      mode_q        <= mode_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_trailer_q   <= m_trailer_d;
      m_last_q      <= m_last_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_trailer   = m_trailer_q;
  assign m_last      = m_last_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/parity_frame_gen.md
Name: parity_frame_gen

Overview:
- Parametrised streaming successor to the 4-bit combinational even-parity generator.
- Accepts WIDTH-bit data words over a valid/ready stream and appends a per-word parity bit (even or odd, chosen per frame).
- After the last word of each frame it emits one trailer beat carrying the longitudinal redundancy check (LRC: bitwise XOR of all words in the frame) plus that word's parity.
- Sits between a framed data source and a serial/link transmitter.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- odd_mode  in  1  parity mode: 0 = even, 1 = odd. Sampled only on the first accepted beat of a frame.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept an input word.
- s_data  in  WIDTH  input word.
- s_last  in  1  input word is the last of the frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts output beat.
- m_data  out  WIDTH+1  {parity_bit, word}; parity_bit is the MSB.
- m_trailer  out  1  current output beat is the LRC trailer.
- m_last  out  1  frame end; asserted only on trailer beats.
- frame_count  out  CNT_W  number of trailer beats accepted downstream; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at clk edge), dominant over every other event:
  - m_valid=0, m_data=0, m_trailer=0, m_last=0, frame_count=0.
  - Internal: state=ST_DATA, lrc=0, first_beat=1, latched mode=0.
  - Any partial frame is discarded. Reset asserted for one cycle is sufficient.
- Parity rule: parity_bit = (^word) XOR mode.
  - Even mode makes the total count of ones in m_data even; odd mode makes it odd.
- Output stage: a single register.
  - The register is free when (!m_valid || m_ready).
  - An m_valid beat holds m_data, m_trailer and m_last stable until m_ready=1.
- State ST_DATA:
  - s_ready = output register free.
  - On accept (s_valid && s_ready), next cycle: m_valid=1, m_data={parity, s_data}, m_trailer=0, m_last=0. Latency is exactly 1 cycle.
  - lrc <= lrc ^ s_data.
  - If first_beat=1: mode <= odd_mode, and this beat's parity uses the live odd_mode. first_beat <= 0.
  - Later beats use the latched mode; odd_mode changes mid-frame are ignored.
  - If s_last is accepted, go to ST_TRAIL.
- State ST_TRAIL:
  - s_ready=0.
  - When the output register is free, load m_data={(^lrc_final) XOR mode, lrc_final}, m_trailer=1, m_last=1. lrc_final includes the last word.
  - Then clear lrc to 0, set first_beat=1, return to ST_DATA.
  - The trailer follows the last data beat with no bubble when m_ready stays high.
- Throughput: one beat per cycle with m_ready held at 1; a frame of N words occupies N+1 output cycles.
- Backpressure: when m_ready=0 with m_valid=1, s_ready=0. No beat is lost or duplicated.
- frame_count increments by 1 on every cycle where m_valid && m_ready && m_trailer. 2^CNT_W-1 wraps to 0.
- Single-word frame (s_last on first beat): parity beat then trailer. The trailer word equals the data word.
- An all-zero frame in even mode produces trailer m_data=0.

Test Plan:
- WIDTH=8, even, m_ready=1; send 0x01, 0x03(last) -> m_data 0x101, 0x003, then trailer 0x102 with m_trailer=m_last=1; each beat 1 cycle after accept; frame_count=1.
- Same frame with odd_mode=1 -> 0x001, 0x103, trailer 0x002.
- Single beat 0xFF(last), even -> 0x0FF then trailer 0x0FF; frame_count increments.
- Send 0x0F with odd_mode=0, toggle odd_mode=1, send 0xF0(last) -> 0x00F, 0x0F0, trailer 0x0FF; mode stays latched even.
- Hold m_ready=0 for 3 cycles while m_valid=1 -> m_data stable, s_ready=0, no input consumed; release -> beats resume in order, none lost.
- Send 0xAA, assert rst_n=0 one cycle, then 0x55(last) even -> after reset m_valid=0 and frame_count=0; outputs 0x055, trailer 0x055 (0xAA excluded from LRC).
